gb_clk_sequencer: RTL and testbench

Controller for the Game Boy oscillator drive. It derives the DMG X1 clock (clkout) from the FPGA system clock and sequences it: free-run, run-N-cycles (step), or stop. It also halts the Game Boy on a bus-read breakpoint, capturing the clkout cycle number at which the read occurred. It sits between the PLL clock domain and the clkout pin. It replaces the bare divider/enable flop and the fixed 0x100 capture logic.

---
 rtl/gb_clk_sequencer.sv | 159 +++++++++++++++
 tb/tb_gb_clk_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_clk_sequencer.sv
// Game Boy X1 clock sequencer.
// Divides the system clock down to clkout and lets it free-run, run a fixed
// number of cycles, or stop. Halts on a ROM read breakpoint and records the
// clkout cycle number of the matching read. Halting only completes with
// clkout low, so a stop never shortens a half-period.
module gb_clk_sequencer #(
  parameter int HALF   = 8,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              cmd_step,
  input  logic [STEP_W-1:0] step_len,
  input  logic              bp_en,
  input  logic [14:0]       bp_adr,
  input  logic [14:0]       adr,
  input  logic              nrd,
  input  logic              ncs,
  output logic              clkout,
  output logic              busy,
  output logic [1:0]        state,
  output logic              bp_hit,
  output logic [31:0]       cycle_count,
  output logic [31:0]       bp_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [15:0] PH_LAST = 16'(HALF - 1);

  state_t            state_q, state_d;
  logic [15:0]       phase_q, phase_d;
  logic              clkout_q, clkout_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              pend_q, pend_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [31:0]       bpc_q, bpc_d;
  logic              hit_q, hit_d;

  logic              busy_w;
  logic              stop_ok;
  logic              step_ok;
  logic              start_ok;

  assign busy_w = (state_q == S_RUN) || (state_q == S_STEP);

  // Next-state: command arbitration, divider, rise/fall events, breakpoint.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    clkout_d = clkout_q;
    rem_d    = rem_q;
    pend_d   = pend_q;
    cyc_d    = cyc_q;
    bpc_d    = bpc_q;
    hit_d    = hit_q;
    stop_ok  = 1'b0;
    step_ok  = 1'b0;
    start_ok = 1'b0;

    // Only the highest-priority asserted command is considered; if it is
    // not legal in the current state the cycle is a no-op for commands.
    if (cmd_stop) begin
      stop_ok = busy_w;
    end else if (cmd_step) begin
      step_ok = !busy_w;
    end else if (cmd_start) begin
      start_ok = !busy_w;
    end

    if (start_ok || step_ok) begin
      hit_d   = 1'b0;
      pend_d  = 1'b0;
      phase_d = 16'd0;
      if (start_ok) begin
        state_d = S_RUN;
      end else if (step_len != '0) begin
        rem_d   = step_len;
        state_d = S_STEP;
      end else begin
        state_d = S_HALT;
      end
    end else if (busy_w) begin
      if (stop_ok && !clkout_q && (phase_q == 16'd0)) begin
        // Nothing of the current low phase has elapsed yet: halt right away.
        state_d = S_HALT;
        phase_d = 16'd0;
        pend_d  = 1'b0;
      end else begin
        if (stop_ok) begin
          pend_d = 1'b1;
        end
        if (phase_q == PH_LAST) begin
          phase_d  = 16'd0;
          clkout_d = !clkout_q;
          if (!clkout_q) begin
            // Rising event.
            cyc_d = cyc_q + 32'd1;
            if (state_q == S_STEP) begin
              rem_d = rem_q - STEP_W'(1);
              if (rem_q == STEP_W'(1)) begin
                pend_d = 1'b1;
              end
            end
            if (bp_en && !hit_q && !nrd && !ncs && (adr == bp_adr)) begin
              hit_d  = 1'b1;
              bpc_d  = cyc_q;
              pend_d = 1'b1;
            end
          end else if (pend_q) begin
            // Falling event with a stop outstanding: park with clkout low.
            pend_d  = 1'b0;
            state_d = S_HALT;
          end
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
    end
  end

  // State and counter registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= 16'd0;
      clkout_q <= 1'b0;
      rem_q    <= '0;
      pend_q   <= 1'b0;
      cyc_q    <= 32'd0;
      bpc_q    <= 32'd0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      clkout_q <= clkout_d;
      rem_q    <= rem_d;
      pend_q   <= pend_d;
      cyc_q    <= cyc_d;
      bpc_q    <= bpc_d;
      hit_q    <= hit_d;
    end
  end

  assign clkout      = clkout_q;
  assign busy        = busy_w;
  assign state       = state_q;
  assign bp_hit      = hit_q;
  assign cycle_count = cyc_q;
  assign bp_count    = bpc_q;

endmodule

// File: tb/tb_gb_clk_sequencer.sv
// Bench for gb_clk_sequencer: two instances (HALF=2 and HALF=4) share the
// command and bus inputs; each scenario resets both and then looks at one.
module tb_gb_clk_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_start, cmd_stop, cmd_step;
  logic [15:0] step_len;
  logic        bp_en;
  logic [14:0] bp_adr, adr;
  logic        nrd, ncs;

  logic        clkout2, busy2, bp_hit2;
  logic [1:0]  state2;
  logic [31:0] cc2, bpc2;
  logic        clkout4, busy4, bp_hit4;
  logic [1:0]  state4;
  logic [31:0] cc4, bpc4;

  int n_tests = 0;
  int n_fail  = 0;

  gb_clk_sequencer #(.HALF(2), .STEP_W(16)) u2 (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_step(cmd_step), .step_len(step_len), .bp_en(bp_en), .bp_adr(bp_adr),
    .adr(adr), .nrd(nrd), .ncs(ncs), .clkout(clkout2), .busy(busy2),
    .state(state2), .bp_hit(bp_hit2), .cycle_count(cc2), .bp_count(bpc2));

  gb_clk_sequencer #(.HALF(4), .STEP_W(16)) u4 (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_step(cmd_step), .step_len(step_len), .bp_en(bp_en), .bp_adr(bp_adr),
    .adr(adr), .nrd(nrd), .ncs(ncs), .clkout(clkout4), .busy(busy4),
    .state(state4), .bp_hit(bp_hit4), .cycle_count(cc4), .bp_count(bpc4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic o_clk(input bit big);
    return big ? clkout4 : clkout2;
  endfunction

  function automatic logic o_busy(input bit big);
    return big ? busy4 : busy2;
  endfunction

  // Reference: number of busy cycles for a free run stopped by cmd_stop
  // presented on busy cycle j (1-based). Low phases are the even-numbered
  // half-periods; a stop in a high half-period ends with that half-period,
  // a stop in a low half-period waits for the next high one to end.
  function automatic int stop_busy(input int j, input int h);
    int  m;
    bit  hi;
    m  = (j - 1) / h;
    hi = (m % 2) == 1;
    if (!hi && ((j - 1) % h) == 0) return j;
    if (hi) return ((j % h) == 0) ? (m + 3) * h : (m + 1) * h;
    return (m + 2) * h;
  endfunction

  task automatic bus_match();
    adr = bp_adr; nrd = 1'b0; ncs = 1'b0;
  endtask

  // Bus traffic that is one term away from a breakpoint match.
  task automatic bus_near();
    logic [14:0] one;
    one = 15'd1;
    case ($urandom % 3)
      0: begin adr = bp_adr; nrd = 1'b1; ncs = 1'($urandom); end
      1: begin adr = bp_adr; nrd = 1'b0; ncs = 1'b1; end
      default: begin adr = bp_adr ^ (one << ($urandom % 15)); nrd = 1'b0; ncs = 1'b0; end
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue start or step, then watch one instance until busy drops.
  // k_bp>0 presents a matching read on the k-th rise; j_stop>0 issues
  // cmd_stop on busy cycle j_stop. Returns busy cycle count, rise count
  // and the number of half-periods whose width differs from h.
  task automatic run_seq(input bit big, input bit is_step, input int slen,
                         input int k_bp, input int j_stop,
                         output int nbusy, output int nrise, output int nbad);
    int   h, run;
    logic prev, cur;
    bit   done;
    h = big ? 4 : 2;
    nbusy = 0; nrise = 0; nbad = 0; run = 0; prev = 1'b0; done = 1'b0;
    if (is_step) begin cmd_step = 1'b1; step_len = 16'(slen); end
    else cmd_start = 1'b1;
    bus_near();
    for (int j = 1; j <= 4000; j++) begin
      @(negedge clk);
      cmd_start = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
      if (!o_busy(big)) begin done = 1'b1; break; end
      nbusy++;
      cur = o_clk(big);
      if (cur !== prev) begin
        if (run != h) nbad++;
        run = 0;
        if (cur) nrise++;
      end
      run++;
      prev = cur;
      if (j == j_stop) cmd_stop = 1'b1;
      if (k_bp > 0 && j == (2 * k_bp - 1) * h) bus_match();
      else bus_near();
    end
    if (prev && run != h) nbad++;
    chk("run_terminates", 32'(done), 32'd1);
  endtask

  int nb, nr, nbd, base, k, j, h, exp_b;
  bit big;

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    step_len = 16'd0; bp_en = 1'b0; bp_adr = 15'h100; adr = 15'd0;
    nrd = 1'b1; ncs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_state", state2, 0);
    chk("rst_clkout", clkout2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_cycle_count", cc2, 0);
    chk("rst_bp_count", bpc2, 0);
    chk("rst_bp_hit", bp_hit2, 0);

    // step with step_len 0: straight to HALT, no edges
    cmd_step = 1'b1; step_len = 16'd0;
    @(negedge clk);
    cmd_step = 1'b0;
    chk("step0_state", state2, 3);
    chk("step0_busy", busy2, 0);
    repeat (10) @(negedge clk);
    chk("step0_cycle_count", cc2, 0);
    chk("step0_clkout", clkout2, 0);

    // step 5 with HALF=2
    run_seq(1'b0, 1'b1, 5, 0, 0, nb, nr, nbd);
    chk("step5_busy_cycles", nb, 20);
    chk("step5_rises", nr, 5);
    chk("step5_widths", nbd, 0);
    chk("step5_cycle_count", cc2, 5);
    chk("step5_state", state2, 3);
    chk("step5_busy", busy2, 0);
    chk("step5_clkout", clkout2, 0);

    // Random step lengths
    for (int i = 0; i < 3; i++) begin
      k = $urandom_range(1, 12);
      base = cc2;
      run_seq(1'b0, 1'b1, k, 0, 0, nb, nr, nbd);
      chk("rstep_busy_cycles", nb, 4 * k);
      chk("rstep_rises", nr, k);
      chk("rstep_widths", nbd, 0);
      chk("rstep_cycle_count", cc2, base + k);
      chk("rstep_state", state2, 3);
    end

    // Breakpoint on the rise that takes cycle_count 37 -> 38
    do_reset();
    bp_en = 1'b1; bp_adr = 15'h100;
    run_seq(1'b0, 1'b0, 0, 38, 0, nb, nr, nbd);
    chk("bp_hit", bp_hit2, 1);
    chk("bp_count", bpc2, 37);
    chk("bp_cycle_count", cc2, 38);
    chk("bp_busy_cycles", nb, 152);
    chk("bp_widths", nbd, 0);
    chk("bp_state", state2, 3);
    chk("bp_clkout", clkout2, 0);

    // stop+start together in HALT: stop wins and is illegal -> no change
    cmd_stop = 1'b1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0; cmd_start = 1'b0;
    chk("halt_stopstart_state", state2, 3);
    chk("halt_stopstart_hit", bp_hit2, 1);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("restart_state", state2, 1);
    chk("restart_hit_cleared", bp_hit2, 0);
    chk("restart_bp_count_held", bpc2, 37);
    bp_en = 1'b0;
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    repeat (8) @(negedge clk);
    chk("restart_stopped", state2, 3);

    // Breakpoint and step exhaustion on the same rise
    for (int i = 0; i < 2; i++) begin
      bp_en = 1'b1; bp_adr = 15'($urandom);
      k = $urandom_range(1, 10);
      base = cc2;
      run_seq(1'b0, 1'b1, k, k, 0, nb, nr, nbd);
      chk("bpstep_hit", bp_hit2, 1);
      chk("bpstep_bp_count", bpc2, base + k - 1);
      chk("bpstep_cycle_count", cc2, base + k);
      chk("bpstep_busy_cycles", nb, 4 * k);
    end

    // Matching read with bp_en low is ignored
    bp_en = 1'b0;
    base = cc2;
    run_seq(1'b0, 1'b0, 0, 3, 30, nb, nr, nbd);
    chk("bpoff_hit", bp_hit2, 0);
    chk("bpoff_busy_cycles", nb, stop_busy(30, 2));

    // HALF=4: stop one clk after the first rise
    do_reset();
    run_seq(1'b1, 1'b0, 0, 0, 5, nb, nr, nbd);
    chk("h4_busy_cycles", nb, 8);
    chk("h4_rises", nr, 1);
    chk("h4_widths", nbd, 0);
    chk("h4_state", state4, 3);
    chk("h4_clkout", clkout4, 0);
    repeat (20) @(negedge clk);
    chk("h4_no_more_rises", cc4, 1);

    // Random stop points on either instance
    for (int i = 0; i < 6; i++) begin
      do_reset();
      big = 1'($urandom);
      h = big ? 4 : 2;
      j = (i == 0) ? 1 : $urandom_range(1, 40);
      exp_b = stop_busy(j, h);
      run_seq(big, 1'b0, 0, 0, j, nb, nr, nbd);
      chk("rstop_busy_cycles", nb, exp_b);
      chk("rstop_rises", nr, exp_b / (2 * h));
      chk("rstop_widths", nbd, 0);
      chk("rstop_cycle_count", big ? cc4 : cc2, exp_b / (2 * h));
      chk("rstop_state", big ? state4 : state2, 3);
      chk("rstop_clkout", o_clk(big), 0);
    end

    // IDLE: stop+start together ignored, then start alone runs
    do_reset();
    cmd_stop = 1'b1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0; cmd_start = 1'b0;
    chk("idle_stopstart_state", state2, 0);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("idle_start_state", state2, 1);
    chk("idle_start_busy", busy2, 1);

    // Asynchronous reset in the middle of a high phase
    do_reset();
    cmd_start = 1'b1;
    repeat (11) begin
      @(negedge clk);
      cmd_start = 1'b0;
    end
    chk("pre_arst_clkout", clkout2, 1);
    chk("pre_arst_cycle_count", cc2, 3);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_clkout", clkout2, 0);
    chk("arst_state", state2, 0);
    chk("arst_busy", busy2, 0);
    chk("arst_cycle_count", cc2, 0);
    chk("arst_bp_count", bpc2, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
